shift_cmd_queue: RTL and testbench
==================================

// Module: shift_cmd_queue
// PURPOSE
//  Command queue directly upstream of the 8-bit multifunction barrel shifter.
//  Buffers shift commands {operand, amount, direction} from a bursty producer.
//  Presents the oldest command on a_out/amt_out/sel_out, wired straight to the
//  shifter's a_in/amt_in/sel_in; consumer pops once the shifter result is taken.
// PARAMETERS
//  DEPTH  4  queue entries; power of 2, >= 2
//  AW     2  pointer width = log2(DEPTH); count_out is AW+1 bits
// PORTS
//  clk_in     in   1     single clock, all state on rising edge
//  rst_n_in   in   1     reset, asynchronous assert, active-low
//  push_in    in   1     write {a_in,amt_in,sel_in} this cycle
//  a_in       in   8     operand to shift
//  amt_in     in   3     shift/rotate amount 0..7
//  sel_in     in   1     direction select, passed through unmodified
//  full_out   out  1     1 = count_out == DEPTH
//  pop_in     in   1     consumer has used head entry; retire it
//  valid_out  out  1     1 = head entry present (count_out != 0)
//  a_out      out  8     head operand      -> shifter a_in
//  amt_out    out  3     head amount       -> shifter amt_in
//  sel_out    out  1     head direction    -> shifter sel_in
//  count_out  out  AW+1  entries held, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x 12-bit array {a,amt,sel}; wr_ptr, rd_ptr AW bits, wrap mod DEPTH.
//  - Reset (rst_n_in=0, async): wr_ptr=rd_ptr=0, count_out=0, valid_out=0,
//    full_out=0; a_out/amt_out/sel_out = 0. Array contents not cleared.
//  - Reset mid-operation discards all queued commands; first push after release
//    is the new head.
//  - Show-ahead: head fields are driven from array[rd_ptr] while valid_out=1,
//    forced to 0 while valid_out=0 (shifter then sees a_in=0).
//  - Latency: push at edge N -> entry visible on head outputs after edge N when
//    queue was empty (valid_out rises same cycle as count_out 0->1).
//  - Accept rules per edge:
//      push_acc = push_in & (~full_out | pop_in)
//      pop_acc  = pop_in & valid_out
//      count_out += push_acc - pop_acc
//  - Push while full without pop: dropped, no state change.
//  - Pop while empty: ignored; count never underflows.
//  - Push+pop while full: both accepted, count stays DEPTH, head advances.
//  - Push+pop while empty: pop ignored, push accepted, count 0 -> 1.
//  - Push+pop otherwise: both accepted, count unchanged.
//  - full_out, valid_out decoded from registered count_out (no comb path from
//    push_in/pop_in to flags); head fields depend only on rd_ptr and array.
//  - FIFO order strict; no reordering, fields never modified.
// CONFIGURATION
//  SHIFT_QUEUE_ERR_FLAG_EN
//   defined:   extra port err_out (out, 1): sticky, set on the edge after a
//              dropped push (full, no pop) or ignored pop (empty); cleared only
//              by rst_n_in. Queue behaviour otherwise identical.
//   undefined: no err_out port; drops and ignored pops are silent.
// TESTING
//  1 Reset: rst_n_in=0 -> count_out=0, valid_out=0, full_out=0, a_out=8'h00.
//  2 Push {8'b11110000,3'd2,0} then {8'b11110000,3'd2,1}: head a_out=8'hF0,
//    amt_out=2, sel_out=0; after pop, sel_out=1; after 2nd pop valid_out=0.
//  3 Fill DEPTH=4 with a=8'h01..8'h04 -> full_out=1; push 8'h05 alone dropped,
//    (err_out=1 if ERR_FLAG_EN); pops return 01,02,03,04 in order.
//  4 Full queue, push 8'hAA with pop same edge -> count_out stays 4, head 8'h02,
//    8'hAA emerges after three more pops.
//  5 Empty queue, push 8'h5A with pop same edge -> count_out=1, head 8'h5A.
//  6 Assert rst_n_in asynchronously mid-clock with 3 entries -> valid_out=0
//    immediately, count_out=0; next push 8'hC3 is head.

Source files
------------

// File: rtl/shift_cmd_queue.sv
// Command queue in front of the 8-bit barrel shifter.
// Holds {operand, amount, direction} commands and shows the oldest one on the head outputs.
// Optional feature: define SHIFT_QUEUE_ERR_FLAG_EN to add a sticky err_out port.
// err_out flags a dropped push or an ignored pop.
module shift_cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push_in,
  input  logic [7:0]    a_in,
  input  logic [2:0]    amt_in,
  input  logic          sel_in,
  output logic          full_out,
  input  logic          pop_in,
  output logic          valid_out,
  output logic [7:0]    a_out,
  output logic [2:0]    amt_out,
  output logic          sel_out,
  output logic [AW:0]   count_out
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
  ,
  output logic          err_out
`endif
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  // Entry layout: {a[7:0], amt[2:0], sel}
  logic [11:0]   mem_q [DEPTH];
  logic [11:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_acc, pop_acc;
  logic [11:0]   head;

  // Flags come only from the registered count, so no comb path from push/pop.
  always_comb begin
    full_out  = (count_q == FullCnt);
    valid_out = (count_q != '0);
    count_out = count_q;
    push_acc  = push_in & (~full_out | pop_in);
    pop_acc   = pop_in & valid_out;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = {a_in, amt_in, sel_in};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards all queued commands.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is deliberately not reset; pointers make stale data unreachable.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  // Show-ahead head; zeroed while empty so the shifter sees a_in = 0.
  always_comb begin
    head    = valid_out ? mem_q[rd_ptr_q] : 12'h000;
    a_out   = head[11:4];
    amt_out = head[3:1];
    sel_out = head[0];
  end

`ifdef SHIFT_QUEUE_ERR_FLAG_EN
  logic err_q, err_d;

  // Sticky error: dropped push (full, no pop) or pop while empty.
  always_comb begin
    err_d = err_q | (push_in & full_out & ~pop_in) | (pop_in & ~valid_out);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: directed table, async-reset sequence, randomized run vs queue model.
module tb_shift_cmd_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          push_in, pop_in, sel_in;
  logic [7:0]    a_in;
  logic [2:0]    amt_in;
  logic          full_out, valid_out, sel_out;
  logic [7:0]    a_out;
  logic [2:0]    amt_out;
  logic [AW:0]   count_out;
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
  logic          err_out;
`endif

  int checks = 0;
  int errors = 0;

  shift_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push_in  (push_in),
    .a_in     (a_in),
    .amt_in   (amt_in),
    .sel_in   (sel_in),
    .full_out (full_out),
    .pop_in   (pop_in),
    .valid_out(valid_out),
    .a_out    (a_out),
    .amt_out  (amt_out),
    .sel_out  (sel_out),
    .count_out(count_out)
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
    ,
    .err_out  (err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] a;
    logic [2:0] amt;
    logic       sel;
    logic [2:0] e_cnt;
    logic [7:0] e_a;
    logic [2:0] e_amt;
    logic       e_sel;
    logic       e_err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic push, input logic pop, input logic [7:0] a,
                      input logic [2:0] amt, input logic sel);
    @(negedge clk_in);
    push_in = push;
    pop_in  = pop;
    a_in    = a;
    amt_in  = amt;
    sel_in  = sel;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_head(input string tag, input int cnt, input logic [7:0] a,
                            input logic [2:0] amt, input logic sel);
    check({tag, " count"}, int'(count_out), cnt);
    check({tag, " valid"}, int'(valid_out), int'(cnt != 0));
    check({tag, " full"},  int'(full_out),  int'(cnt == DEPTH));
    check({tag, " a"},     int'(a_out),     int'(a));
    check({tag, " amt"},   int'(amt_out),   int'(amt));
    check({tag, " sel"},   int'(sel_out),   int'(sel));
  endtask

  logic [11:0] model_q[$];
  logic        model_err;

  initial begin
    // {push, pop, a, amt, sel, exp count, exp a, exp amt, exp sel, exp err}
    vecs[0]  = '{1'b1, 1'b0, 8'hF0, 3'd2, 1'b0, 3'd1, 8'hF0, 3'd2, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'hF0, 3'd2, 1'b1, 3'd2, 8'hF0, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd1, 8'hF0, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h01, 3'd1, 1'b1, 3'd1, 8'h01, 3'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h02, 3'd2, 1'b0, 3'd2, 8'h01, 3'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 8'h03, 3'd3, 1'b1, 3'd3, 8'h01, 3'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h04, 3'd4, 1'b0, 3'd4, 8'h01, 3'd1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h05, 3'd7, 1'b1, 3'd4, 8'h01, 3'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'hAA, 3'd5, 1'b1, 3'd4, 8'h02, 3'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd3, 8'h03, 3'd3, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd2, 8'h04, 3'd4, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd1, 8'hAA, 3'd5, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 8'h5A, 3'd6, 1'b0, 3'd1, 8'h5A, 3'd6, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b1};

    rst_n_in = 1'b0;
    push_in  = 1'b0;
    pop_in   = 1'b0;
    a_in     = 8'h00;
    amt_in   = 3'd0;
    sel_in   = 1'b0;

    // Reset state
    #12;
    check_head("reset", 0, 8'h00, 3'd0, 1'b0);
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
    check("reset err", int'(err_out), 0);
`endif
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].a, vecs[i].amt, vecs[i].sel);
      check_head($sformatf("vec%0d", i), int'(vecs[i].e_cnt), vecs[i].e_a, vecs[i].e_amt,
                 vecs[i].e_sel);
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
      check($sformatf("vec%0d err", i), int'(err_out), int'(vecs[i].e_err));
`endif
    end

    // Async reset mid-clock with three entries held
    step(1'b1, 1'b0, 8'h11, 3'd1, 1'b0);
    step(1'b1, 1'b0, 8'h22, 3'd2, 1'b1);
    step(1'b1, 1'b0, 8'h33, 3'd3, 1'b0);
    check("pre-reset count", int'(count_out), 3);
    @(negedge clk_in);
    push_in = 1'b0;
    pop_in  = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    check_head("async reset", 0, 8'h00, 3'd0, 1'b0);
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
    check("async reset err", int'(err_out), 0);
`endif
    @(posedge clk_in);
    #1;
    check("reset held count", int'(count_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(1'b1, 1'b0, 8'hC3, 3'd7, 1'b1);
    check_head("post-reset push", 1, 8'hC3, 3'd7, 1'b1);
    step(1'b0, 1'b1, 8'h00, 3'd0, 1'b0);
    check_head("post-reset pop", 0, 8'h00, 3'd0, 1'b0);

    // Randomized run against a queue model
    model_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       p, q, s, m_full, m_valid;
      logic [7:0] a;
      logic [2:0] am;
      logic [11:0] hd;
      p  = ($urandom_range(0, 99) < 55);
      q  = ($urandom_range(0, 99) < 45);
      a  = 8'($urandom);
      am = 3'($urandom);
      s  = 1'($urandom);
      m_full  = (model_q.size() == DEPTH);
      m_valid = (model_q.size() != 0);
      if ((p && m_full && !q) || (q && !m_valid)) model_err = 1'b1;
      if (q && m_valid) void'(model_q.pop_front());
      if (p && (!m_full || q)) model_q.push_back({a, am, s});
      step(p, q, a, am, s);
      hd = (model_q.size() != 0) ? model_q[0] : 12'h000;
      check_head($sformatf("rand%0d", n), model_q.size(), hd[11:4], hd[3:1], hd[0]);
`ifdef SHIFT_QUEUE_ERR_FLAG_EN
      check($sformatf("rand%0d err", n), int'(err_out), int'(model_err));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
